// File: rtl/seq_detection_prog.sv
// seq_detection_prog
// Programmable sequence detector. Each enabled clock accepts one SYM_W-bit
// symbol into a history shift register. The detector flags when the most
// recent cfg_len symbols match a stored pattern, where each pattern bit
// can be marked don't-care. Overlapping and non-overlapping modes are both
// supported, and a saturating match counter is kept.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   clr       : synchronous active-high reset
//   en        : symbol valid, sym is accepted when en=1
//   sym       : input symbol
//   cfg_we    : pattern write strobe; flushes history fill and drops en
//   cfg_addr  : pattern position to write (0 = first symbol of sequence)
//   cfg_sym   : expected symbol for that position
//   cfg_care  : per-bit compare enable (1 = compare, 0 = don't care)
//   cfg_len   : active pattern length, 1..MAX_LEN (other values never match)
//   overlap   : 1 = overlapping matches, 0 = history restarts after a match
//   Z         : registered one-cycle match pulse
//   match_cnt : saturating match count
//   fill      : number of valid symbols currently in the history
module seq_detection_prog #(
    parameter int SYM_W   = 2,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int AW      = $clog2(MAX_LEN),
    parameter int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [SYM_W-1:0] sym,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [SYM_W-1:0] cfg_sym,
    input  logic [SYM_W-1:0] cfg_care,
    input  logic [LW-1:0]    cfg_len,
    input  logic             overlap,
    output logic             Z,
    output logic [CNT_W-1:0] match_cnt,
    output logic [LW-1:0]    fill
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [LW-1:0]    LEN_MAX  = LW'(MAX_LEN);
    // One extra bit so the bound check stays meaningful when MAX_LEN is a power of two.
    localparam logic [AW:0]      ADDR_LIM = (AW + 1)'(MAX_LEN);

    logic [SYM_W-1:0] pat_r  [MAX_LEN];
    logic [SYM_W-1:0] care_r [MAX_LEN];
    logic [SYM_W-1:0] hist_r [MAX_LEN];
    logic [LW-1:0]    fill_r;
    logic             z_r;
    logic [CNT_W-1:0] cnt_r;

    logic [SYM_W-1:0] hist_n_s [MAX_LEN];
    logic [LW-1:0]    fill_n_s;
    logic             addr_ok_s;
    logic             len_ok_s;
    logic             mism_s;
    logic             match_s;
    logic [AW-1:0]    pidx_s;

    // Post-shift history as it would look if the current symbol were accepted.
    always_comb begin
        hist_n_s[0] = sym;
        for (int i = 1; i < MAX_LEN; i++) begin
            hist_n_s[i] = hist_r[i-1];
        end
    end

    // Next fill count, saturating at MAX_LEN.
    always_comb begin
        if (fill_r >= LEN_MAX) begin
            fill_n_s = fill_r;
        end else begin
            fill_n_s = fill_r + LW'(1);
        end
    end

    // Write address and length qualification.
    always_comb begin
        addr_ok_s = ({1'b0, cfg_addr} < ADDR_LIM);
        len_ok_s  = (cfg_len != {LW{1'b0}}) && (cfg_len <= LEN_MAX) && (fill_n_s >= cfg_len);
    end

    // Masked compare: newest symbol hist_n[i] lines up with pattern position L-1-i.
    always_comb begin
        mism_s = 1'b0;
        pidx_s = {AW{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            if (len_ok_s && (i < int'(cfg_len))) begin
                pidx_s = AW'(int'(cfg_len) - 1 - i);
                if (((hist_n_s[i] ^ pat_r[pidx_s]) & care_r[pidx_s]) != {SYM_W{1'b0}}) begin
                    mism_s = 1'b1;
                end else begin
                    mism_s = mism_s;
                end
            end else begin
                mism_s = mism_s;
            end
        end
        match_s = len_ok_s && !mism_s;
    end

    // Pattern storage, history, fill, match pulse and counter.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                pat_r[i]  <= {SYM_W{1'b0}};
                care_r[i] <= {SYM_W{1'b1}};
                hist_r[i] <= {SYM_W{1'b0}};
            end
            fill_r <= {LW{1'b0}};
            z_r    <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (cfg_we) begin
            // A pattern write flushes the history; any concurrent symbol is dropped.
            if (addr_ok_s) begin
                pat_r[cfg_addr]  <= cfg_sym;
                care_r[cfg_addr] <= cfg_care;
            end
            fill_r <= {LW{1'b0}};
            z_r    <= 1'b0;
        end else if (en) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                hist_r[i] <= hist_n_s[i];
            end
            if (match_s) begin
                z_r    <= 1'b1;
                cnt_r  <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
                fill_r <= overlap ? fill_n_s : {LW{1'b0}};
            end else begin
                z_r    <= 1'b0;
                fill_r <= fill_n_s;
            end
        end else begin
            z_r <= 1'b0;
        end
    end

    assign Z         = z_r;
    assign match_cnt = cnt_r;
    assign fill      = fill_r;

endmodule

// File: tb/tb_seq_detection_prog.sv
// Scoreboard bench for seq_detection_prog (SYM_W=2, MAX_LEN=8, CNT_W=2).
// Each driven clock pushes its hand-computed {Z, match_cnt, fill}; a monitor
// pops one entry per clock, 1 time unit after the edge, and compares.
module tb_seq_detection_prog;

    localparam int SYM_W   = 2;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int AW      = 3;
    localparam int LW      = 4;

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic             en = 1'b0;
    logic [SYM_W-1:0] sym = 2'b00;
    logic             cfg_we = 1'b0;
    logic [AW-1:0]    cfg_addr = 3'd0;
    logic [SYM_W-1:0] cfg_sym = 2'b00;
    logic [SYM_W-1:0] cfg_care = 2'b00;
    logic [LW-1:0]    cfg_len = 4'd3;
    logic             overlap = 1'b0;
    logic             Z;
    logic [CNT_W-1:0] match_cnt;
    logic [LW-1:0]    fill;

    typedef struct packed {
        logic             z;
        logic [CNT_W-1:0] cnt;
        logic [LW-1:0]    fl;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  mon_e;
    int    checks = 0;
    int    errors = 0;
    string phase  = "reset";

    seq_detection_prog #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .clr(clr), .en(en), .sym(sym),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sym(cfg_sym), .cfg_care(cfg_care),
        .cfg_len(cfg_len), .overlap(overlap),
        .Z(Z), .match_cnt(match_cnt), .fill(fill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s [%s]: got %0d expected %0d", name, phase, act, expv);
        end
    endtask

    // Monitor: one expected entry per clock edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("Z", int'(Z), int'(mon_e.z));
            chk("match_cnt", int'(match_cnt), int'(mon_e.cnt));
            chk("fill", int'(fill), int'(mon_e.fl));
        end
    end

    task automatic step(input logic c, input logic e, input logic [1:0] s, input logic w,
                        input logic [2:0] a, input logic [1:0] cs, input logic [1:0] cc,
                        input logic ez, input int ec, input int ef);
        exp_t x;
        clr = c; en = e; sym = s; cfg_we = w; cfg_addr = a; cfg_sym = cs; cfg_care = cc;
        x.z = ez; x.cnt = CNT_W'(ec); x.fl = LW'(ef);
        exp_q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic sym_in(input logic [1:0] s, input logic ez, input int ec, input int ef);
        step(1'b0, 1'b1, s, 1'b0, 3'd0, 2'b00, 2'b00, ez, ec, ef);
    endtask

    task automatic idle(input int ec, input int ef);
        step(1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 2'b00, 2'b00, 1'b0, ec, ef);
    endtask

    task automatic wr(input logic [2:0] a, input logic [1:0] s, input logic [1:0] c, input int ec);
        step(1'b0, 1'b0, 2'b00, 1'b1, a, s, c, 1'b0, ec, 0);
    endtask

    task automatic do_clr();
        step(1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 2'b00, 2'b00, 1'b0, 0, 0);
    endtask

    // Pattern 01,11,01 with full care.
    task automatic load_pat(input int ec);
        wr(3'd0, 2'b01, 2'b11, ec);
        wr(3'd1, 2'b11, 2'b11, ec);
        wr(3'd2, 2'b01, 2'b11, ec);
    endtask

    initial begin
        // Basic non-overlap match
        phase = "basic";
        do_clr();
        load_pat(0);
        cfg_len = 4'd3; overlap = 1'b0;
        sym_in(2'b01, 1'b0, 0, 1);
        sym_in(2'b11, 1'b0, 0, 2);
        sym_in(2'b01, 1'b1, 1, 0);

        // Overlap mode: pulses after symbols 3 and 5
        phase = "overlap1";
        do_clr();
        load_pat(0);
        overlap = 1'b1;
        idle(0, 0);
        sym_in(2'b01, 1'b0, 0, 1);
        sym_in(2'b11, 1'b0, 0, 2);
        sym_in(2'b01, 1'b1, 1, 3);
        sym_in(2'b11, 1'b0, 1, 4);
        sym_in(2'b01, 1'b1, 2, 5);

        // Same stream, non-overlap: single pulse
        phase = "overlap0";
        do_clr();
        load_pat(0);
        overlap = 1'b0;
        idle(0, 0);
        sym_in(2'b01, 1'b0, 0, 1);
        sym_in(2'b11, 1'b0, 0, 2);
        sym_in(2'b01, 1'b1, 1, 0);
        sym_in(2'b11, 1'b0, 1, 1);
        sym_in(2'b01, 1'b0, 1, 2);

        // Don't-care on bit0 of position 1
        phase = "care";
        wr(3'd1, 2'b11, 2'b10, 1);
        sym_in(2'b01, 1'b0, 1, 1);
        sym_in(2'b10, 1'b0, 1, 2);
        sym_in(2'b01, 1'b1, 2, 0);
        sym_in(2'b01, 1'b0, 2, 1);
        sym_in(2'b00, 1'b0, 2, 2);
        sym_in(2'b01, 1'b0, 2, 3);

        // en=0 gaps inside a matching sequence
        phase = "gaps";
        do_clr();
        load_pat(0);
        sym_in(2'b01, 1'b0, 0, 1);
        idle(0, 1);
        idle(0, 1);
        sym_in(2'b11, 1'b0, 0, 2);
        idle(0, 2);
        sym_in(2'b01, 1'b1, 1, 0);
        idle(1, 0);

        // Counter saturation at 3 (five matches in total)
        phase = "saturate";
        for (int k = 0; k < 4; k++) begin
            sym_in(2'b01, 1'b0, (k + 1 > 3) ? 3 : k + 1, 1);
            sym_in(2'b11, 1'b0, (k + 1 > 3) ? 3 : k + 1, 2);
            sym_in(2'b01, 1'b1, (k + 2 > 3) ? 3 : k + 2, 0);
        end

        // Pattern write concurrent with the completing symbol
        phase = "we_concurrent";
        sym_in(2'b01, 1'b0, 3, 1);
        sym_in(2'b11, 1'b0, 3, 2);
        step(1'b0, 1'b1, 2'b01, 1'b1, 3'd0, 2'b01, 2'b11, 1'b0, 3, 0);
        sym_in(2'b01, 1'b0, 3, 1);

        // cfg_len=0 and >MAX_LEN never match; fill saturates; history survives len change
        phase = "len_bounds";
        do_clr();
        load_pat(0);
        cfg_len = 4'd0;
        idle(0, 0);
        sym_in(2'b01, 1'b0, 0, 1);
        sym_in(2'b11, 1'b0, 0, 2);
        sym_in(2'b01, 1'b0, 0, 3);
        for (int k = 0; k < 6; k++) begin
            sym_in(2'b00, 1'b0, 0, (k + 4 > 8) ? 8 : k + 4);
        end
        cfg_len = 4'd9;
        idle(0, 8);
        sym_in(2'b01, 1'b0, 0, 8);
        sym_in(2'b11, 1'b0, 0, 8);
        sym_in(2'b01, 1'b0, 0, 8);
        cfg_len = 4'd3;
        idle(0, 8);
        sym_in(2'b01, 1'b0, 0, 8);
        sym_in(2'b11, 1'b0, 0, 8);
        sym_in(2'b01, 1'b1, 1, 0);

        // clr mid-sequence; afterwards the reset pattern (00,00,00) applies
        phase = "clr_mid";
        do_clr();
        load_pat(0);
        sym_in(2'b01, 1'b0, 0, 1);
        sym_in(2'b11, 1'b0, 0, 2);
        do_clr();
        sym_in(2'b01, 1'b0, 0, 1);
        sym_in(2'b00, 1'b0, 0, 2);
        sym_in(2'b00, 1'b0, 0, 3);
        sym_in(2'b00, 1'b1, 1, 0);

        // Drain the scoreboard, bounded
        phase = "drain";
        idle(1, 0);
        for (int k = 0; k < 5; k++) begin
            if (exp_q.size() != 0) begin
                @(posedge clk);
                #2;
            end
        end
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
